// File: rtl/rt_types_pkg.sv
// Shared types and constants for the perspective-divide stage.
// Optional PERSP_DIV_RECIP_EN: one reciprocal divide plus three multiplies.
`ifndef WIDTH
`define WIDTH 16
`endif
`ifndef Q_BITS
`define Q_BITS 12
`endif

package rt_types_pkg;

    localparam logic [`WIDTH-1:0] ONE_Q = `WIDTH'(1 << `Q_BITS);

`ifdef PERSP_DIV_RECIP_EN
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_MUL,
        ST_DONE
    } persp_state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_DONE
    } persp_state_t;
`endif

endpackage

// File: rtl/perspective_divide_divider.sv
// Sequential fixed-point divider: quotient = (dividend << Q_BITS) / divisor, truncated.
// Magnitudes are divided; sign correction is applied combinationally on the live inputs.
`ifndef WIDTH
`define WIDTH 16
`endif
`ifndef Q_BITS
`define Q_BITS 12
`endif

module divider #(
    parameter int WIDTH  = `WIDTH,
    parameter int Q_BITS = `Q_BITS
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic signed [WIDTH-1:0] dividend,
    input  logic signed [WIDTH-1:0] divisor,
    output logic                    ready,
    output logic                    valid,
    output logic signed [WIDTH-1:0] quotient
);
    localparam int N  = WIDTH + Q_BITS;
    localparam int CW = $clog2(N + 1);

    logic [WIDTH-1:0] rem_reg;
    logic [WIDTH-1:0] dvs_reg;
    logic [N-1:0]     quo_reg;
    logic [CW-1:0]    cnt_reg;
    logic             busy_reg;
    logic             valid_reg;

    logic [WIDTH:0]   rem_shift;
    logic             rem_ge;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] q_mag;

    function automatic logic [WIDTH-1:0] mag(input logic signed [WIDTH-1:0] v);
        return v[WIDTH-1] ? WIDTH'(-v) : v;
    endfunction

    // One restoring-division step per cycle, fixed N iterations.
    always_comb begin
        rem_shift = {rem_reg, quo_reg[N-1]};
        rem_ge    = rem_shift >= {1'b0, dvs_reg};
        rem_next  = rem_ge ? WIDTH'(rem_shift - {1'b0, dvs_reg}) : WIDTH'(rem_shift);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rem_reg   <= '0;
            dvs_reg   <= '0;
            quo_reg   <= '0;
            cnt_reg   <= '0;
            busy_reg  <= 1'b0;
            valid_reg <= 1'b0;
        end else begin
            valid_reg <= 1'b0;
            if (start && !busy_reg) begin
                quo_reg  <= {mag(dividend), {Q_BITS{1'b0}}};
                rem_reg  <= '0;
                dvs_reg  <= mag(divisor);
                cnt_reg  <= CW'(N);
                busy_reg <= 1'b1;
            end else if (busy_reg) begin
                rem_reg <= rem_next;
                quo_reg <= {quo_reg[N-2:0], rem_ge};
                cnt_reg <= cnt_reg - 1'b1;
                if (cnt_reg == CW'(1)) begin
                    busy_reg  <= 1'b0;
                    valid_reg <= 1'b1;
                end
            end
        end
    end

    assign q_mag    = quo_reg[WIDTH-1:0];
    assign quotient = (dividend[WIDTH-1] ^ divisor[WIDTH-1]) ? WIDTH'(-q_mag) : q_mag;
    assign ready    = !busy_reg;
    assign valid    = valid_reg;

endmodule

// File: rtl/perspective_divide.sv
// Perspective divide: x/w, y/w, z/w and 1/w in Q3.12 through one shared divider.
// PERSP_DIV_RECIP_EN: divide only 1/w, then scale x, y, z by it in the MUL state.
`ifndef WIDTH
`define WIDTH 16
`endif
`ifndef Q_BITS
`define Q_BITS 12
`endif

module perspective_divide
    import rt_types_pkg::*;
#(
    parameter int WIDTH  = `WIDTH,
    parameter int Q_BITS = `Q_BITS
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] in_x,
    input  logic signed [WIDTH-1:0] in_y,
    input  logic signed [WIDTH-1:0] in_z,
    input  logic signed [WIDTH-1:0] in_w,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [WIDTH-1:0] out_x,
    output logic signed [WIDTH-1:0] out_y,
    output logic signed [WIDTH-1:0] out_z,
    output logic signed [WIDTH-1:0] out_inv_w,
    output logic                    out_clip
);
    persp_state_t            state_reg, state_next;
    logic signed [WIDTH-1:0] x_reg, y_reg, z_reg, w_reg, div_num_reg;
    logic signed [WIDTH-1:0] res_reg [4];
    logic [1:0]              op_reg;
    logic                    clip_reg;

    logic                    accept;
    logic                    res_we;
    logic signed [WIDTH-1:0] res_wd;
    logic                    div_start, div_ready, div_valid;
    logic signed [WIDTH-1:0] div_quotient;

    function automatic logic signed [WIDTH-1:0] operand_sel(
        input logic [1:0] op, input logic signed [WIDTH-1:0] a, b, c);
        case (op)
            2'd1:    return a;
            2'd2:    return b;
            default: return c;
        endcase
    endfunction

    divider #(.WIDTH(WIDTH), .Q_BITS(Q_BITS)) u_div (
        .clk      (clk),
        .reset    (reset),
        .start    (div_start),
        .dividend (div_num_reg),
        .divisor  (w_reg),
        .ready    (div_ready),
        .valid    (div_valid),
        .quotient (div_quotient)
    );

`ifdef PERSP_DIV_RECIP_EN
    logic signed [2*WIDTH-1:0] mul_prod;
    assign mul_prod = operand_sel(op_reg, x_reg, y_reg, z_reg) * res_reg[0];
`endif

    assign accept = (state_reg == ST_IDLE) && in_valid;

    always_comb begin
        state_next = state_reg;
        div_start  = 1'b0;
        res_we     = 1'b0;
        res_wd     = div_quotient;
        in_ready   = (state_reg == ST_IDLE);
        out_valid  = (state_reg == ST_DONE);
        case (state_reg)
            ST_IDLE: begin
                if (in_valid)
                    state_next = (in_w == '0) ? ST_DONE : ST_ISSUE;
            end
            ST_ISSUE: begin
                if (div_ready) begin
                    div_start  = 1'b1;
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (div_valid) begin
                    res_we = 1'b1;
`ifdef PERSP_DIV_RECIP_EN
                    state_next = ST_MUL;
`else
                    state_next = (op_reg == 2'd3) ? ST_DONE : ST_ISSUE;
`endif
                end
            end
`ifdef PERSP_DIV_RECIP_EN
            ST_MUL: begin
                res_we = 1'b1;
                res_wd = WIDTH'(mul_prod >>> Q_BITS);
                if (op_reg == 2'd3)
                    state_next = ST_DONE;
            end
`endif
            ST_DONE: begin
                if (out_ready)
                    state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // op_reg selects both the result register being written and the next dividend.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= ST_IDLE;
            x_reg       <= '0;
            y_reg       <= '0;
            z_reg       <= '0;
            w_reg       <= '0;
            div_num_reg <= '0;
            op_reg      <= '0;
            clip_reg    <= 1'b0;
            for (int i = 0; i < 4; i++) res_reg[i] <= '0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                x_reg       <= in_x;
                y_reg       <= in_y;
                z_reg       <= in_z;
                w_reg       <= in_w;
                clip_reg    <= (in_w <= 0);
                op_reg      <= '0;
                div_num_reg <= WIDTH'(ONE_Q);
                for (int i = 0; i < 4; i++) res_reg[i] <= '0;
            end else if (res_we) begin
                res_reg[op_reg] <= res_wd;
                op_reg          <= op_reg + 2'd1;
`ifndef PERSP_DIV_RECIP_EN
                div_num_reg     <= operand_sel(op_reg + 2'd1, x_reg, y_reg, z_reg);
`endif
            end
        end
    end

    assign out_inv_w = res_reg[0];
    assign out_x     = res_reg[1];
    assign out_y     = res_reg[2];
    assign out_z     = res_reg[3];
    assign out_clip  = clip_reg;

endmodule

// File: tb/tb_perspective_divide.sv
// Directed, table-driven bench for perspective_divide (default and PERSP_DIV_RECIP_EN builds).
module tb_perspective_divide;

    logic        clk;
    logic        reset;
    logic        in_valid, in_ready;
    logic [15:0] in_x, in_y, in_z, in_w;
    logic        out_valid, out_ready;
    logic [15:0] out_x, out_y, out_z, out_inv_w;
    logic        out_clip;

    perspective_divide dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .in_y      (in_y),
        .in_z      (in_z),
        .in_w      (in_w),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_x     (out_x),
        .out_y     (out_y),
        .out_z     (out_z),
        .out_inv_w (out_inv_w),
        .out_clip  (out_clip)
    );

    typedef struct {
        logic [15:0] x, y, z, w;
        logic [15:0] ex, ey, ez, einv;
        logic        eclip;
    } vec_t;

    vec_t vecs [6];
    int   checks    = 0;
    int   failures  = 0;
    int   cyc       = 0;
    int   start_cnt = 0;
    int   start_cyc = 0;
    int   l_meas    = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Divider activity probe: counts start pulses and measures start-to-valid latency.
    always @(negedge clk) begin
        if (dut.div_start) begin
            start_cyc = cyc;
            start_cnt = start_cnt + 1;
        end
        if (dut.div_valid) l_meas = cyc - start_cyc;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
        end
    endtask

    task automatic run_vec(input int idx, input int hold);
        vec_t        v;
        int          n, acc, s0, lat, exp_lat, starts, exp_starts;
        logic        stable;
        logic [15:0] sx, sy, sz, si;
        v = vecs[idx];
        n = 0;
        while (!in_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("v%0d_in_ready_before", idx), in_ready, 1);
        in_x = v.x; in_y = v.y; in_z = v.z; in_w = v.w;
        in_valid = 1'b1;
        acc = cyc;
        s0  = start_cnt;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        chk($sformatf("v%0d_in_ready_busy", idx), in_ready, 0);
        n = 0;
        while (!out_valid && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("v%0d_out_valid_seen", idx), out_valid, 1);
        if (!out_valid) return;
        lat    = cyc - acc;
        starts = start_cnt - s0;
        if (v.w == 16'h0000) begin
            exp_lat    = 1;
            exp_starts = 0;
        end else begin
`ifdef PERSP_DIV_RECIP_EN
            exp_lat    = l_meas + 5;
            exp_starts = 1;
`else
            exp_lat    = 4 * (1 + l_meas) + 1;
            exp_starts = 4;
`endif
        end
        chk($sformatf("v%0d_latency", idx), lat, exp_lat);
        chk($sformatf("v%0d_div_starts", idx), starts, exp_starts);
        chk($sformatf("v%0d_out_x", idx), out_x, v.ex);
        chk($sformatf("v%0d_out_y", idx), out_y, v.ey);
        chk($sformatf("v%0d_out_z", idx), out_z, v.ez);
        chk($sformatf("v%0d_out_inv_w", idx), out_inv_w, v.einv);
        chk($sformatf("v%0d_out_clip", idx), out_clip, v.eclip);
        $display("vec %0d x=%h y=%h z=%h w=%h -> x=%h y=%h z=%h inv_w=%h clip=%0b lat=%0d",
                 idx, v.x, v.y, v.z, v.w, out_x, out_y, out_z, out_inv_w, out_clip, lat);
        if (hold > 0) begin
            sx = out_x; sy = out_y; sz = out_z; si = out_inv_w;
            stable = 1'b1;
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                if (!out_valid || in_ready || out_x !== sx || out_y !== sy ||
                    out_z !== sz || out_inv_w !== si)
                    stable = 1'b0;
            end
            chk($sformatf("v%0d_hold_stable", idx), stable, 1);
            in_valid = 1'b1;  // offered during the output handshake; must not be taken
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        @(negedge clk);
        chk($sformatf("v%0d_out_valid_after_take", idx), out_valid, 0);
        chk($sformatf("v%0d_in_ready_after_take", idx), in_ready, 1);
    endtask

    initial begin
        int n, s0;
        vecs[0] = '{16'h2000, 16'hF000, 16'h0800, 16'h2000, 16'h1000, 16'hF800, 16'h0400, 16'h0800, 1'b0};
        vecs[1] = '{16'h2000, 16'hF000, 16'h0800, 16'hE000, 16'hF000, 16'h0800, 16'hFC00, 16'hF800, 1'b1};
        vecs[2] = '{16'h2000, 16'hF000, 16'h0800, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b1};
        vecs[3] = '{16'h1000, 16'h3000, 16'hF800, 16'h4000, 16'h0400, 16'h0C00, 16'hFE00, 16'h0400, 1'b0};
        vecs[4] = '{16'h1800, 16'h0000, 16'h0400, 16'hF000, 16'hE800, 16'h0000, 16'hFC00, 16'hF000, 1'b1};
        vecs[5] = '{16'h1000, 16'hF000, 16'h0000, 16'h3000, 16'h0555, 16'hFAAB, 16'h0000, 16'h0555, 1'b0};

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_x = '0; in_y = '0; in_z = '0; in_w = '0;
        repeat (2) @(negedge clk);
        chk("reset_in_ready", in_ready, 1);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_outputs", {out_x, out_y}, 32'h0);
        chk("reset_out_z_inv", {out_z, out_inv_w}, 32'h0);
        chk("reset_out_clip", out_clip, 0);
        chk("reset_div_start", dut.div_start, 0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 6; i++) run_vec(i, 0);

        // Back-pressure: hold the result for 10 cycles, then take it.
        run_vec(0, 10);

        // Asynchronous reset during a divide in flight.
        in_x = vecs[0].x; in_y = vecs[0].y; in_z = vecs[0].z; in_w = vecs[0].w;
        in_valid = 1'b1;
        s0 = start_cnt;
        @(posedge clk);
        #1 in_valid = 1'b0;
        n = 0;
`ifdef PERSP_DIV_RECIP_EN
        while (start_cnt < s0 + 1 && n < 500) begin
`else
        while (start_cnt < s0 + 2 && n < 500) begin
`endif
            @(negedge clk);
            n++;
        end
        chk("rst_target_wait_reached", (n < 500), 1);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rst_async_in_ready", in_ready, 1);
        chk("rst_async_out_valid", out_valid, 0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_outputs", {out_x, out_y}, 32'h0);
        chk("rst_out_z_inv", {out_z, out_inv_w}, 32'h0);
        chk("rst_out_clip", out_clip, 0);
        chk("rst_div_ready", dut.div_ready, 1);
        chk("rst_in_ready", in_ready, 1);
        $display("reset mid-divide applied, in_ready=%0b out_valid=%0b", in_ready, out_valid);
        run_vec(0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
